// File: rtl/reg_scoreboard_if.sv
// Scoreboard bus: ID-stage issue offer, WB retire port, flush, and the
// stall/busy status returned by the scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
);
    logic            issue_valid;
    logic            issue_we;
    logic [AW-1:0]   issue_waddr;
    logic            rs1_used;
    logic [AW-1:0]   rs1_addr;
    logic            rs2_used;
    logic [AW-1:0]   rs2_addr;
    logic            wb_we;
    logic [AW-1:0]   wb_waddr;
    logic            flush;
    logic            stall;
    logic            issue_fire;
    logic [NREG-1:0] busy_vec;
    logic            pending_any;
    logic            sb_err;

    modport master (
        output issue_valid, issue_we, issue_waddr,
        output rs1_used, rs1_addr, rs2_used, rs2_addr,
        output wb_we, wb_waddr, flush,
        input  stall, issue_fire, busy_vec, pending_any, sb_err
    );

    modport slave (
        input  issue_valid, issue_we, issue_waddr,
        input  rs1_used, rs1_addr, rs2_used, rs2_addr,
        input  wb_we, wb_waddr, flush,
        output stall, issue_fire, busy_vec, pending_any, sb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the in-order pipeline.
// Counts issued-but-unretired writes per architectural register (r0 untracked)
// and raises the ID-stage stall on RAW hazards or a saturated WAW counter.
// Optional: define SB_WB_BYPASS_EN to let a source whose last pending write
// is retiring this cycle proceed (WB data is forwarded to ID).
module reg_scoreboard #(
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    reg_scoreboard_if.slave  sb
);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_sb_err;

    logic [CNT_W-1:0] w_cnt_rs1;
    logic [CNT_W-1:0] w_cnt_rs2;
    logic [CNT_W-1:0] w_cnt_wa;
    logic [CNT_W-1:0] w_cnt_wb;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_byp1;
    logic             w_byp2;
    logic             w_waw_full;
    logic             w_stall;
    logic             w_fire;
    logic             w_underflow;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;
    logic [NREG-1:0]  w_busy;

    // Hazard detection from current counters and same-cycle offer
    always_comb begin
        w_cnt_rs1  = r_cnt[sb.rs1_addr];
        w_cnt_rs2  = r_cnt[sb.rs2_addr];
        w_cnt_wa   = r_cnt[sb.issue_waddr];
        w_cnt_wb   = r_cnt[sb.wb_waddr];
        w_raw1     = sb.rs1_used && (sb.rs1_addr != '0) && (w_cnt_rs1 != '0);
        w_raw2     = sb.rs2_used && (sb.rs2_addr != '0) && (w_cnt_rs2 != '0);
`ifdef SB_WB_BYPASS_EN
        w_byp1     = (w_cnt_rs1 == CNT_W'(1)) && sb.wb_we && (sb.wb_waddr == sb.rs1_addr);
        w_byp2     = (w_cnt_rs2 == CNT_W'(1)) && sb.wb_we && (sb.wb_waddr == sb.rs2_addr);
`else
        w_byp1     = 1'b0;
        w_byp2     = 1'b0;
`endif
        w_waw_full = sb.issue_we && (sb.issue_waddr != '0) && (w_cnt_wa == '1);
        w_stall    = sb.issue_valid && !sb.flush &&
                     ((w_raw1 && !w_byp1) || (w_raw2 && !w_byp2) || w_waw_full);
        // resetn gates fire so an offer during reset is ignored
        w_fire     = resetn && sb.issue_valid && !sb.flush && !w_stall;
    end

    // Per-register increment/decrement requests and underflow detection
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_inc[i] = w_fire && sb.issue_we && (sb.issue_waddr == AW'(i));
            w_dec[i] = sb.wb_we && (sb.wb_waddr == AW'(i));
        end
        w_underflow = !sb.flush && sb.wb_we && (sb.wb_waddr != '0) &&
                      (w_cnt_wb == '0) && !w_inc[sb.wb_waddr];
    end

    // Pending-write counters; flush clears, simultaneous inc+dec cancel
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else if (sb.flush) begin
            for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
        end
    end

    // Sticky retire-without-pending-write error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          r_sb_err <= 1'b0;
        else if (w_underflow) r_sb_err <= 1'b1;
    end

    // Busy decode straight from the counter registers
    always_comb begin
        w_busy = '0;
        for (int unsigned i = 1; i < NREG; i++) w_busy[i] = (r_cnt[i] != '0);
    end

    assign sb.stall       = w_stall;
    assign sb.issue_fire  = w_fire;
    assign sb.busy_vec    = w_busy;
    assign sb.pending_any = |w_busy;
    assign sb.sb_err      = r_sb_err;

endmodule
